// File: rtl/text_disp_pkg.sv
// Shared types for the text display controller's pixel path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package text_disp_pkg;

    localparam int COLOR_BITS  = 12;
    localparam int MIN_SCANPIX = 3;

    typedef logic [COLOR_BITS-1:0] color_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ser_state_t;

    typedef struct packed {
        color_t fg;
        color_t bg;
        logic   cursor;
    } cell_attr_t;

endpackage

// File: rtl/char_cell_timer.sv
// Cell timer: line state, dot counter, cell width latch and fetch strobe.
// Latency: first ce one clock after line_start, then one ce every W+1 clocks.
// Backpressure: none; free-running on the dot clock while the line is active.
module char_cell_timer
    import text_disp_pkg::*;
#(
    parameter int pMinScanpix = MIN_SCANPIX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       line_start,
    input  logic       active,
    input  logic [5:0] max_scanpix,
    output logic       ce,
    output logic [5:0] width,
    output logic       running
);

    localparam logic [5:0] MIN_W = 6'(pMinScanpix);

    ser_state_t state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] w_q, w_d;
    logic       ce_d;

    // Next state, counter and width; the width is relatched only on a strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        if (ce) begin
            w_d = (max_scanpix < MIN_W) ? MIN_W : max_scanpix;
        end
        case (state_q)
            IDLE: begin
                if (line_start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (line_start) begin
                    cnt_d = '0;
                end else if (!active) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == w_d) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Registered strobe: high exactly in the counter-0 cycles of RUN
        ce_d = (state_d == RUN) && (cnt_d == 6'd0);
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            ce      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            ce      <= ce_d;
        end
    end

    assign width   = w_q;
    assign running = (state_q == RUN);

endmodule

// File: rtl/char_dot_serializer.sv
// Glyph-row serializer: fetch strobe, one-cell attribute delay, dot shift-out with colour.
// Latency: first dot of a cell 2 clocks after its load strobe; first cell of a line is priming.
// Backpressure: none; one dot per clock while the line is active.
module char_dot_serializer
    import text_disp_pkg::*;
#(
    parameter int pColorBits  = COLOR_BITS,
    parameter int pMinScanpix = MIN_SCANPIX
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  line_start_i,
    input  logic                  active_i,
    input  logic [5:0]            maxScanpix_i,
    input  logic [63:0]           bmp_i,
    input  logic [pColorBits-1:0] fg_i,
    input  logic [pColorBits-1:0] bg_i,
    input  logic                  cursor_i,
    input  logic                  blink_i,
    input  logic [pColorBits-1:0] border_i,
    output logic                  ce_o,
    output logic [pColorBits-1:0] pix_o,
    output logic                  pix_on_o,
    output logic                  pix_valid_o
);

    logic       ce;
    logic [5:0] width;
    logic       running;

    char_cell_timer #(
        .pMinScanpix (pMinScanpix)
    ) u_timer (
        .clk         (clk_i),
        .rst_n       (rst_ni),
        .line_start  (line_start_i),
        .active      (active_i),
        .max_scanpix (maxScanpix_i),
        .ce          (ce),
        .width       (width),
        .running     (running)
    );

    assign ce_o = ce;

    cell_attr_t stage_a, stage_b;
    logic       load_q;      // cycle after a strobe: bmp_i holds the row to load
    logic [63:0] sreg;       // remaining dots, next dot at bit 63
    logic       seen_q;      // a strobe has already happened on this line
    logic       pend_q;      // the row returned after the latest strobe is real text
    logic       cell_ok_q;   // the cell currently shifting out is real text

    logic                  cur_bit;
    logic                  cur_ok;
    logic                  dot_vld;
    logic                  swap;
    logic [pColorBits-1:0] fg_c;
    logic [pColorBits-1:0] bg_c;

    // Select the dot for this clock: straight from bmp_i on load, else the shifter head
    always_comb begin
        cur_bit = load_q ? bmp_i[width] : sreg[63];
        cur_ok  = load_q ? pend_q : cell_ok_q;
        dot_vld = running && cur_ok && !line_start_i;
        swap    = stage_b.cursor && blink_i;
        fg_c    = swap ? stage_b.bg : stage_b.fg;
        bg_c    = swap ? stage_b.fg : stage_b.bg;
    end

    // Attribute pipeline, row shifter, priming bookkeeping and registered pixel outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_a     <= '0;
            stage_b     <= '0;
            load_q      <= 1'b0;
            sreg        <= '0;
            seen_q      <= 1'b0;
            pend_q      <= 1'b0;
            cell_ok_q   <= 1'b0;
            pix_valid_o <= 1'b0;
            pix_on_o    <= 1'b0;
            pix_o       <= '0;
        end else begin
            load_q <= ce;
            if (ce) begin
                stage_a <= '{fg: fg_i, bg: bg_i, cursor: cursor_i};
                stage_b <= stage_a;
            end
            // On load the first dot (bit W) goes straight out; bit W-1 lands at the head
            if (load_q) begin
                sreg <= bmp_i << (7'd64 - {1'b0, width});
            end else begin
                sreg <= sreg << 1;
            end
            // The row after a line's first strobe belongs to the previous line: never show it
            if (line_start_i) begin
                seen_q    <= 1'b0;
                pend_q    <= 1'b0;
                cell_ok_q <= 1'b0;
            end else begin
                if (ce) begin
                    pend_q <= seen_q;
                    seen_q <= 1'b1;
                end
                if (load_q) begin
                    cell_ok_q <= pend_q;
                end
            end
            pix_valid_o <= dot_vld;
            pix_on_o    <= dot_vld && cur_bit;
            pix_o       <= dot_vld ? (cur_bit ? fg_c : bg_c) : border_i;
        end
    end

endmodule

// File: tb/tb_char_dot_serializer.sv
// Directed and randomized checks of char_dot_serializer against a cell-level reference model.
// Latency: checks every output every cycle.
// Backpressure: n/a.
module tb_char_dot_serializer;

    localparam int N = 8192;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        line_start_i = 1'b0;
    logic        active_i = 1'b1;
    logic [5:0]  maxScanpix_i = 6'd7;
    logic [63:0] bmp_i = '0;
    logic [11:0] fg_i = '0;
    logic [11:0] bg_i = '0;
    logic        cursor_i = 1'b0;
    logic        blink_i = 1'b0;
    logic [11:0] border_i = 12'h00F;
    logic        ce_o;
    logic [11:0] pix_o;
    logic        pix_on_o;
    logic        pix_valid_o;

    char_dot_serializer dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .line_start_i (line_start_i),
        .active_i     (active_i),
        .maxScanpix_i (maxScanpix_i),
        .bmp_i        (bmp_i),
        .fg_i         (fg_i),
        .bg_i         (bg_i),
        .cursor_i     (cursor_i),
        .blink_i      (blink_i),
        .border_i     (border_i),
        .ce_o         (ce_o),
        .pix_o        (pix_o),
        .pix_on_o     (pix_on_o),
        .pix_valid_o  (pix_valid_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Reference model: expected dot per cycle, filled in whole cells at each fetch strobe
    logic        exp_v   [0:N-1];
    logic        exp_bit [0:N-1];
    logic [11:0] exp_fg  [0:N-1];
    logic [11:0] exp_bg  [0:N-1];
    logic        exp_cur [0:N-1];
    logic        rst_h   [0:N-1];
    logic        blink_h [0:N-1];
    logic [11:0] border_h[0:N-1];

    bit          running = 1'b0;
    bit          primed = 1'b0;
    int          next_ce = 0;
    logic [11:0] prev_fg = '0;
    logic [11:0] prev_bg = '0;
    logic        prev_cur = 1'b0;
    bit          use_rand = 1'b0;
    logic [63:0] glyph_fixed = 64'hA5;
    bit          drive_bmp = 1'b0;
    logic [63:0] bmp_next = '0;

    task automatic clear_from(input int n);
        for (int i = n; i < n + 80; i++) exp_v[i] = 1'b0;
    endtask

    task automatic check_now();
        logic        e_ce;
        logic        e_v;
        logic        e_on;
        logic [11:0] e_pix;
        e_ce = running && (cyc == next_ce);
        if (rst_h[cyc-1]) begin
            e_v = 1'b0; e_on = 1'b0; e_pix = '0;
        end else if (exp_v[cyc]) begin
            e_v  = 1'b1;
            e_on = exp_bit[cyc];
            if (exp_cur[cyc] && blink_h[cyc-1])
                e_pix = e_on ? exp_bg[cyc] : exp_fg[cyc];
            else
                e_pix = e_on ? exp_fg[cyc] : exp_bg[cyc];
        end else begin
            e_v = 1'b0; e_on = 1'b0; e_pix = border_h[cyc-1];
        end
        vectors++;
        assert (ce_o === e_ce) else begin
            miscompares++;
            $error("FAIL ce_o cyc=%0d got=%b exp=%b", cyc, ce_o, e_ce);
        end
        vectors++;
        assert (pix_valid_o === e_v) else begin
            miscompares++;
            $error("FAIL pix_valid cyc=%0d got=%b exp=%b", cyc, pix_valid_o, e_v);
        end
        vectors++;
        assert (pix_on_o === e_on) else begin
            miscompares++;
            $error("FAIL pix_on cyc=%0d got=%b exp=%b", cyc, pix_on_o, e_on);
        end
        vectors++;
        assert (pix_o === e_pix) else begin
            miscompares++;
            $error("FAIL pix cyc=%0d got=%h exp=%h", cyc, pix_o, e_pix);
        end
    endtask

    // Advance the model through the current cycle's inputs
    task automatic model_cycle();
        int w;
        logic [63:0] g;
        rst_h[cyc]    = !rst_ni;
        blink_h[cyc]  = blink_i;
        border_h[cyc] = border_i;
        drive_bmp     = 1'b0;
        if (!rst_ni) begin
            running = 1'b0;
            clear_from(cyc + 1);
            return;
        end
        if (running && cyc == next_ce) begin
            w = (int'(maxScanpix_i) < 3) ? 3 : int'(maxScanpix_i);
            g = use_rand ? {$urandom, $urandom} : glyph_fixed;
            drive_bmp = 1'b1;
            bmp_next  = g;
            if (primed) begin
                for (int k = 0; k <= w; k++) begin
                    exp_v[cyc+2+k]   = 1'b1;
                    exp_bit[cyc+2+k] = g[w-k];
                    exp_fg[cyc+2+k]  = prev_fg;
                    exp_bg[cyc+2+k]  = prev_bg;
                    exp_cur[cyc+2+k] = prev_cur;
                end
            end
            primed   = 1'b1;
            prev_fg  = fg_i;
            prev_bg  = bg_i;
            prev_cur = cursor_i;
            next_ce  = cyc + w + 1;
        end
        if (line_start_i) begin
            clear_from(cyc + 1);
            running = 1'b1;
            primed  = 1'b0;
            next_ce = cyc + 1;
        end else if (running && !active_i) begin
            clear_from(cyc + 2);
            running = 1'b0;
        end
    endtask

    task automatic tick();
        check_now();
        model_cycle();
        @(posedge clk_i);
        #1;
        cyc++;
        if (drive_bmp) bmp_i = bmp_next;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start();
        line_start_i = 1'b1;
        tick();
        line_start_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            exp_v[i] = 1'b0; exp_bit[i] = 1'b0; exp_fg[i] = '0; exp_bg[i] = '0;
            exp_cur[i] = 1'b0; rst_h[i] = 1'b0; blink_h[i] = 1'b0; border_h[i] = '0;
        end
        // Reset held with active high and start pulses; outputs must stay cleared
        rst_h[0] = 1'b1;
        line_start_i = 1'b1;
        @(posedge clk_i);
        #1;
        cyc = 1;
        tick();
        line_start_i = 1'b0;
        tick();
        line_start_i = 1'b1;
        tick();
        rst_ni = 1'b1;
        line_start_i = 1'b0;
        ticks(6);

        // Width 8, 0xA5, white on black
        maxScanpix_i = 6'd7; fg_i = 12'hFFF; bg_i = 12'h000;
        glyph_fixed = 64'hA5;
        pulse_start();
        ticks(30);

        // Width 12, upper bits set and ignored, then a mid-line restart
        maxScanpix_i = 6'd11;
        glyph_fixed = 64'hFFFF_FFFF_FFFF_FC03;
        fg_i = 12'h123; bg_i = 12'hABC;
        pulse_start();
        ticks(30);
        pulse_start();
        ticks(20);

        // Cursor cells with blink on then off
        cursor_i = 1'b1; blink_i = 1'b1; use_rand = 1'b1;
        ticks(30);
        blink_i = 1'b0;
        ticks(20);
        cursor_i = 1'b0;

        // Width below minimum clamps to 4
        maxScanpix_i = 6'd1;
        pulse_start();
        ticks(24);

        // Maximum width 64
        maxScanpix_i = 6'd63;
        pulse_start();
        ticks(140);

        // Active drops mid-cell, line idles, then start coincides with active low
        maxScanpix_i = 6'd7;
        pulse_start();
        ticks(12);
        active_i = 1'b0;
        border_i = 12'h5A5;
        ticks(10);
        line_start_i = 1'b1;
        tick();
        line_start_i = 1'b0;
        ticks(5);
        active_i = 1'b1;
        ticks(25);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            rst_ni       = ($urandom_range(0, 399) != 0);
            line_start_i = running ? ($urandom_range(0, 69) == 0) : ($urandom_range(0, 7) == 0);
            active_i     = ($urandom_range(0, 99) < 98);
            maxScanpix_i = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(0, 63));
            fg_i         = 12'($urandom);
            bg_i         = 12'($urandom);
            cursor_i     = $urandom_range(0, 1) == 1;
            blink_i      = $urandom_range(0, 1) == 1;
            border_i     = 12'($urandom);
            tick();
        end
        rst_ni = 1'b1;
        line_start_i = 1'b0;
        ticks(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/char_dot_serializer.md
Name: char_dot_serializer

Overview:
Consumer end of the character bitmap RAM's glyph-row interface in the text display controller. It generates the per-cell fetch strobe (ce_o), which drives the bitmap RAM and the text address generator. It captures the returned 64-bit glyph row and shifts it out one dot per clock, producing a colour per dot from the per-cell foreground/background attributes and the cursor.
The bitmap RAM returns a cell's glyph row one cell after the fetch strobe, so this block delays the attributes by one cell to match.

Parameters:
pColorBits, 12, width of fg/bg/border/pixel colour.
pMinScanpix, 3, minimum value of maxScanpix; the minimum cell width is 4 dots.

Ports:
clk_i  in  1  dot clock; all logic on its rising edge.
rst_ni  in  1  synchronous active-low reset.
line_start_i  in  1  pulse at the start of the active text region of a scanline.
active_i  in  1  high while the text region is active.
maxScanpix_i  in  6  cell width minus 1, in dots.
bmp_i  in  64  glyph row from the bitmap RAM; updated on the edge where ce_o is high.
fg_i  in  pColorBits  foreground colour of the cell being fetched; sampled with ce_o.
bg_i  in  pColorBits  background colour; sampled with ce_o.
cursor_i  in  1  cell is at the cursor position; sampled with ce_o.
blink_i  in  1  cursor blink phase; 1 means the cursor is visible.
border_i  in  pColorBits  colour output when no pixel is valid.
ce_o  out  1  cell strobe; one clock wide; drives the RAM ce and the char code fetch.
pix_o  out  pColorBits  pixel colour.
pix_on_o  out  1  raw glyph bit of the current dot.
pix_valid_o  out  1  pix_o carries a text pixel.

Behaviour:
- Reset (rst_ni low at an edge):
  - state IDLE, dot counter 0, latched width 0.
  - ce_o 0, pix_valid_o 0, pix_on_o 0, pix_o 0.
  - shift register, both attribute stages and the prime flag all clear.
- Reset asserted mid-line: everything is dropped immediately; no further ce_o until the next line_start_i.
- States:
  - IDLE -> RUN on line_start_i.
  - RUN -> IDLE when active_i is sampled low and line_start_i is low.
  - line_start_i in RUN restarts the line; line_start_i wins over active_i low in the same cycle.
- Cell timing:
  - On entry to RUN, or on restart, the dot counter goes to 0.
  - ce_o is registered and is high for the one cycle in which the counter is 0 in RUN. The first ce_o is therefore the cycle after line_start_i.
  - On each ce_o the block latches W = max(maxScanpix_i, pMinScanpix). The counter counts 0..W and then wraps to 0.
  - A change to maxScanpix_i takes effect only at the next ce_o.
- Attribute alignment:
  - On ce_o, fg/bg/cursor are captured into stage A, and stage A moves into stage B.
  - Stage B always matches the bitmap loaded at the following cycle.
- Bitmap load:
  - The shift register loads bmp_i in the cycle after ce_o.
  - Pixel width is W+1.
  - Dot order is leftmost first: bit W, then W-1, down to bit 0. Bits above W are ignored.
- Output timing and priming:
  - Output is registered. The first dot of a cell appears 2 cycles after its load ce_o, and the cell's dots run contiguously for W+1 cycles.
  - The first cell after line_start_i is a priming cell, because its bmp_i belongs to the previous fetch. Its dots drive pix_valid_o=0.
- Colour:
  - The cursor swaps fg and bg when stage-B cursor and blink_i are both 1; blink_i is sampled at output time.
  - pix_o = pix_on ? fg : bg.
  - When pix_valid_o=0, pix_o = border_i and pix_on_o = 0.
- Flush: after active_i falls, ce_o stops the next cycle and pix_valid_o falls 2 cycles after active_i is sampled low. The timing generator must hold active_i one cell past the last character.
- Width arithmetic: the dot counter is 6 bits and never exceeds 63. A width of 64 (W=63) wraps without overflow.

Decomposition:
- Package text_disp_pkg:
  - color_t
  - serializer state enum {IDLE, RUN}
  - MIN_SCANPIX constant
  - cell_attr_t struct {fg, bg, cursor}
- One sub-module, char_cell_timer: state machine, dot counter, W latch and ce_o generation. The serializer datapath stays in the top.

Test Plan:
1. rst_ni low 3 cycles with active_i=1 and line_start_i pulses -> ce_o=0, pix_valid_o=0, pix_o=0 throughout; after release with no line_start_i, still no ce_o.
2. maxScanpix_i=7, line_start_i at t0, bmp_i=0xA5 after the 2nd ce_o, fg=0xFFF, bg=0x000:
   - ce_o at t1, t9, t17.
   - Cycles t3..t10 valid=0 (priming cell).
   - Dots t11..t18 are 1,0,1,0,0,1,0,1, giving pix_o FFF,000,FFF,000,000,FFF,000,FFF.
3. maxScanpix_i=11, bmp_i=0x0000_0000_0000_0C03 -> 12 dots 1,1,0,0,0,0,0,0,0,0,1,1; bits above 11 ignored; ce_o every 12 cycles.
4. Same cell with cursor_i=1 at its fetch ce_o: blink_i=1 -> fg/bg swapped, pix_on_o unchanged; blink_i=0 -> normal colours.
5. maxScanpix_i=1 -> clamped W=3, ce_o every 4 cycles, 4 dots per cell from bits 3..0.
6. active_i dropped mid-cell at t -> no ce_o after t+1, pix_valid_o=0 from t+2, pix_o=border_i; line_start_i in the same cycle instead restarts with ce_o at t+1.
